// File: rtl/audio_pkg.sv
`default_nettype none
// ==========================================================================
// audio_pkg : timing constants and slot helpers for the I2S DAC transmitter
// Revision  : 1.0
// ==========================================================================
package audio_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int XCK_DIV    = 4;
  localparam int BCLK_DIV   = 16;
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 2 * SLOT_BITS;

  localparam int XCK_W = (XCK_DIV > 2) ? $clog2(XCK_DIV) : 1;
  localparam int PH_W  = $clog2(BCLK_DIV);
  localparam int BIT_W = $clog2(FRAME_BITS);

  // Slot position 0 carries the previous slot's trailing zero (one-BCLK I2S delay).
  function automatic logic is_data_bit(input logic [BIT_W-1:0] idx);
    logic [BIT_W-1:0] pos;
    pos = (idx >= BIT_W'(SLOT_BITS)) ? idx - BIT_W'(SLOT_BITS) : idx;
    return (pos != '0) && (pos <= BIT_W'(SAMPLE_W));
  endfunction

endpackage
`default_nettype wire

// File: rtl/audio_i2s_tx_clkgen.sv
`default_nettype none
// ==========================================================================
// i2s_clkgen : XCK / BCLK / LRCK dividers with bit-fall and frame strobes
// Revision   : 1.0
// ==========================================================================
module i2s_clkgen
  import audio_pkg::*;
(
  input  logic             clk50mhz,
  input  logic             reset,
  output logic             aud_xck_o,
  output logic             aud_bclk_o,
  output logic             aud_lrck_o,
  output logic             bclk_fall_o,
  output logic             frame_start_o,
  output logic [BIT_W-1:0] bit_nxt_o
);

  logic [XCK_W-1:0] xck_q, xck_d;
  logic [PH_W-1:0]  ph_q,  ph_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             xck_out_q, bclk_out_q, lrck_out_q;

  // Strobes are lookahead: they are high in the cycle before BCLK actually falls.
  always_comb begin
    xck_d         = (xck_q == XCK_W'(XCK_DIV - 1)) ? '0 : xck_q + 1'b1;
    bclk_fall_o   = (ph_q == PH_W'(BCLK_DIV - 1));
    ph_d          = bclk_fall_o ? '0 : ph_q + 1'b1;
    bit_d         = bit_q;
    frame_start_o = 1'b0;
    if (bclk_fall_o) begin
      if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
        bit_d         = '0;
        frame_start_o = 1'b1;
      end else begin
        bit_d = bit_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      xck_q      <= '0;
      ph_q       <= '0;
      bit_q      <= '0;
      xck_out_q  <= 1'b0;
      bclk_out_q <= 1'b0;
      lrck_out_q <= 1'b0;
    end else begin
      xck_q      <= xck_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      xck_out_q  <= (xck_d >= XCK_W'(XCK_DIV / 2));
      bclk_out_q <= (ph_d >= PH_W'(BCLK_DIV / 2));
      lrck_out_q <= (bit_d >= BIT_W'(SLOT_BITS));
    end
  end

  assign aud_xck_o  = xck_out_q;
  assign aud_bclk_o = bclk_out_q;
  assign aud_lrck_o = lrck_out_q;
  assign bit_nxt_o  = bit_d;

endmodule
`default_nettype wire

// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ==========================================================================
// audio_i2s_tx : stereo I2S transmitter for the WM8731 codec (codec is slave)
// Revision     : 1.0
// ==========================================================================
module audio_i2s_tx
  import audio_pkg::*;
(
  input  logic                clk50mhz,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                AUD_XCK,
  output logic                AUD_BCLK,
  output logic                AUD_DACLRCK,
  output logic                AUD_DACDAT,
  output logic                frame_strobe,
  output logic                underrun
);

  localparam int FW = 2 * SAMPLE_W;

  logic             bclk_fall;
  logic             frame_start;
  logic [BIT_W-1:0] bit_nxt;

  logic [FW-1:0] hold_q,  hold_d;
  logic [FW-1:0] shift_q, shift_d;
  logic [FW-1:0] last_q,  last_d;
  logic          full_q,  full_d;
  logic          ready_q, ready_d;
  logic          dat_q,   dat_d;
  logic          strb_q,  strb_d;
  logic          undr_q,  undr_d;
  logic          xfer;

  i2s_clkgen u_clkgen (
    .clk50mhz      (clk50mhz),
    .reset         (reset),
    .aud_xck_o     (AUD_XCK),
    .aud_bclk_o    (AUD_BCLK),
    .aud_lrck_o    (AUD_DACLRCK),
    .bclk_fall_o   (bclk_fall),
    .frame_start_o (frame_start),
    .bit_nxt_o     (bit_nxt)
  );

  always_comb begin
    xfer    = sample_valid && ready_q;
    hold_d  = hold_q;
    full_d  = full_q;
    shift_d = shift_q;
    last_d  = last_q;
    dat_d   = dat_q;
    strb_d  = frame_start;
    undr_d  = 1'b0;

    // Shifter holds {left,right}; left drains in the left slot, right in the right slot.
    if (frame_start) begin
      dat_d = 1'b0;
      if (full_q) begin
        shift_d = hold_q;
        last_d  = hold_q;
        full_d  = 1'b0;
      end else begin
        shift_d = last_q;
        undr_d  = 1'b1;
      end
    end else if (bclk_fall) begin
      if (is_data_bit(bit_nxt)) begin
        dat_d   = shift_q[FW-1];
        shift_d = {shift_q[FW-2:0], 1'b0};
      end else begin
        dat_d = 1'b0;
      end
    end

    // A capture coinciding with a load lands after it, so it feeds the next frame.
    if (xfer) begin
      hold_d = {sample_l, sample_r};
      full_d = 1'b1;
    end
    ready_d = !full_d;
  end

  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      hold_q  <= '0;
      shift_q <= '0;
      last_q  <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b1;
      dat_q   <= 1'b0;
      strb_q  <= 1'b0;
      undr_q  <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      full_q  <= full_d;
      ready_q <= ready_d;
      dat_q   <= dat_d;
      strb_q  <= strb_d;
      undr_q  <= undr_d;
    end
  end

  assign sample_ready = ready_q;
  assign AUD_DACDAT   = dat_q;
  assign frame_strobe = strb_q;
  assign underrun     = undr_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
// ==========================================================================
// tb_audio_i2s_tx : scoreboard bench deserialising DACDAT against a frame model
// Revision        : 1.0
// ==========================================================================
module tb_audio_i2s_tx;
  import audio_pkg::*;

  localparam int FRAME_CYC = BCLK_DIV * FRAME_BITS;
  typedef logic [2*SAMPLE_W-1:0] frame_t;

  logic                clk50mhz;
  logic                reset;
  logic [SAMPLE_W-1:0] sample_l, sample_r;
  logic                sample_valid;
  logic                sample_ready, AUD_XCK, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT;
  logic                frame_strobe, underrun;

  audio_i2s_tx dut (
    .clk50mhz     (clk50mhz),
    .reset        (reset),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .AUD_XCK      (AUD_XCK),
    .AUD_BCLK     (AUD_BCLK),
    .AUD_DACLRCK  (AUD_DACLRCK),
    .AUD_DACDAT   (AUD_DACDAT),
    .frame_strobe (frame_strobe),
    .underrun     (underrun)
  );

  initial clk50mhz = 1'b0;
  always #5 clk50mhz = ~clk50mhz;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     k = 0;
  frame_t exp_q[$];
  frame_t rx_q[$];

  // Reference model: frame-level behaviour from the cycle count since reset.
  bit     m_full = 0;
  bit     m_xfer;
  frame_t m_hold = '0;
  frame_t m_last = '0;
  bit     rst_seen = 0;

  always @(posedge clk50mhz) begin
    cyc++;
    if (reset) begin
      k = 0; m_full = 0; m_hold = '0; m_last = '0;
      exp_q.delete();
      exp_q.push_back('0);
      rst_seen = 1;
    end else begin
      m_xfer = sample_valid && !m_full;
      if ((k % FRAME_CYC) == FRAME_CYC - 1) begin
        if (m_full) begin
          exp_q.push_back(m_hold);
          m_last = m_hold;
          m_full = 0;
        end else begin
          exp_q.push_back(m_last);
        end
      end
      if (m_xfer) begin
        m_hold = {sample_l, sample_r};
        m_full = 1;
      end
      k++;
    end
  end

  // Deserialiser: samples DACDAT at each BCLK rise, slot position from LRCK changes.
  int                  bitpos = -1;
  logic                prev_bclk = 0, prev_lrck = 0;
  bit                  have_left = 0;
  logic [SAMPLE_W-1:0] cur_l = '0, cur_r = '0;
  int                  tail_err = 0;
  int                  dut_under_cnt = 0;

  always @(negedge clk50mhz) begin
    if (rst_seen) begin
      rst_seen = 0; rx_q.delete(); bitpos = -1;
      prev_bclk = 0; prev_lrck = 0; have_left = 0;
    end
    if (underrun === 1'b1) dut_under_cnt++;
    if (AUD_BCLK === 1'b1 && prev_bclk === 1'b0) begin
      if (bitpos < 0 || AUD_DACLRCK !== prev_lrck) bitpos = 0;
      else bitpos++;
      prev_lrck = AUD_DACLRCK;
      if (bitpos >= 1 && bitpos <= SAMPLE_W) begin
        if (AUD_DACLRCK) cur_r = {cur_r[SAMPLE_W-2:0], AUD_DACDAT};
        else             cur_l = {cur_l[SAMPLE_W-2:0], AUD_DACDAT};
      end else if (AUD_DACDAT !== 1'b0) begin
        tail_err++;
      end
      if (!AUD_DACLRCK && bitpos == 0) have_left = 1;
      if (AUD_DACLRCK && bitpos == SLOT_BITS - 1) begin
        if (have_left) rx_q.push_back({cur_l, cur_r});
        have_left = 0;
      end
    end
    prev_bclk = AUD_BCLK;
  end

  task automatic wait_strobe(output bit ok);
    ok = 0;
    for (int i = 0; i < FRAME_CYC + 64; i++) begin
      @(negedge clk50mhz);
      if (frame_strobe === 1'b1) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL strobe_timeout: frame_strobe absent for %0d cycles, required within %0d", FRAME_CYC + 64, FRAME_CYC);
    end
  endtask

  task automatic pull_frame(output frame_t f, output bit ok);
    ok = 0; f = '0;
    for (int i = 0; i < 2 * FRAME_CYC; i++) begin
      if (rx_q.size() > 0) begin f = rx_q.pop_front(); ok = 1; break; end
      @(negedge clk50mhz);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL frame_timeout: no serial frame received, required one within %0d cycles", 2 * FRAME_CYC);
    end
  endtask

  task automatic send_sample(input logic [SAMPLE_W-1:0] l, input logic [SAMPLE_W-1:0] r);
    bit ok = 0;
    for (int i = 0; i < 2 * FRAME_CYC; i++) begin
      if (sample_ready === 1'b1) begin ok = 1; break; end
      @(negedge clk50mhz);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL ready_timeout: sample_ready stayed 0, required 1");
    end
    sample_l = l; sample_r = r; sample_valid = 1'b1;
    @(negedge clk50mhz);
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit ok; frame_t f, e; int n;
    reset = 1'b1; sample_valid = 1'b0; sample_l = '0; sample_r = '0;
    repeat (3) @(negedge clk50mhz);
    checks++;
    if ({sample_ready, AUD_XCK, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, frame_strobe, underrun} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 1000000",
               {sample_ready, AUD_XCK, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, frame_strobe, underrun});
    end
    reset = 1'b0;
    wait_strobe(ok);
    checks++;
    if (k !== FRAME_CYC) begin errors++; $display("FAIL first_strobe_time: got cycle %0d required %0d", k, FRAME_CYC); end
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL first_underrun: got %b required 1", underrun); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      pull_frame(f, ok); if (!ok) break;
      e = exp_q.pop_front();
      checks++;
      if (f !== e || f !== '0) begin errors++; $display("FAIL reset_frame[%0d]: got %h required %h", i, f, e); end
    end
  endtask

  task automatic test_single();
    bit ok; frame_t f, e; int n;
    wait_strobe(ok);
    send_sample(16'hA5C3, 16'h0F01);
    checks++;
    if (sample_ready !== 1'b0) begin errors++; $display("FAIL ready_fall: got %b required 0", sample_ready); end
    wait_strobe(ok);
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL single_underrun: got %b required 0", underrun); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      pull_frame(f, ok); if (!ok) break;
      e = exp_q.pop_front();
      checks++;
      if (f !== e) begin errors++; $display("FAIL single_frame[%0d]: got %h required %h", i, f, e); end
      if (i == n - 1) begin
        checks++;
        if (f !== 32'hA5C30F01) begin errors++; $display("FAIL single_value: got %h required a5c30f01", f); end
      end
    end
    checks++;
    if (tail_err !== 0) begin errors++; $display("FAIL tail_zero: got %0d nonzero pad bits required 0", tail_err); end
  endtask

  task automatic test_stream();
    bit ok; frame_t f, e; int n, t_prev; frame_t sent[$];
    logic [SAMPLE_W-1:0] l, r;
    wait_strobe(ok);
    t_prev = cyc;
    for (int j = 0; j < 8; j++) begin
      l = SAMPLE_W'($urandom); r = SAMPLE_W'($urandom);
      sent.push_back({l, r});
      send_sample(l, r);
      wait_strobe(ok);
      checks++;
      if (underrun !== 1'b0) begin errors++; $display("FAIL stream_underrun[%0d]: got %b required 0", j, underrun); end
      checks++;
      if (cyc - t_prev !== FRAME_CYC) begin errors++; $display("FAIL frame_period[%0d]: got %0d required %0d", j, cyc - t_prev, FRAME_CYC); end
      t_prev = cyc;
    end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      pull_frame(f, ok); if (!ok) break;
      e = exp_q.pop_front();
      checks++;
      if (f !== e) begin errors++; $display("FAIL stream_frame[%0d]: got %h required %h", i, f, e); end
      if (i >= n - 8 && sent.size() > 0) begin
        e = sent.pop_front();
        checks++;
        if (f !== e) begin errors++; $display("FAIL stream_value[%0d]: got %h required %h", i, f, e); end
      end
    end
  endtask

  task automatic test_clocks();
    int bh = 0, br = 0, xh = 0, xr = 0, t0 = 0, lr = 0;
    logic pb, px, pl;
    @(negedge clk50mhz);
    pb = AUD_BCLK; px = AUD_XCK;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk50mhz);
      bh += int'(AUD_BCLK); xh += int'(AUD_XCK);
      if (AUD_BCLK && !pb) br++;
      if (AUD_XCK && !px) xr++;
      pb = AUD_BCLK; px = AUD_XCK;
    end
    checks++;
    if (bh !== 32 || br !== 4) begin errors++; $display("FAIL bclk_shape: got high=%0d rises=%0d required 32/4", bh, br); end
    checks++;
    if (xh !== 32 || xr !== 16) begin errors++; $display("FAIL xck_shape: got high=%0d rises=%0d required 32/16", xh, xr); end
    pl = AUD_DACLRCK;
    for (int i = 0; i < 3 * FRAME_CYC && lr < 2; i++) begin
      @(negedge clk50mhz);
      if (AUD_DACLRCK && !pl) begin
        if (lr == 1) begin
          checks++;
          if (cyc - t0 !== FRAME_CYC) begin errors++; $display("FAIL lrck_period: got %0d required %0d", cyc - t0, FRAME_CYC); end
        end
        t0 = cyc; lr++;
      end
      pl = AUD_DACLRCK;
    end
    if (lr < 2) begin checks++; errors++; $display("FAIL lrck_timeout: got %0d rises required 2", lr); end
  endtask

  task automatic test_starve();
    bit ok; frame_t f, e; int n, u0;
    wait_strobe(ok);
    send_sample(16'h8000, 16'h7FFF);
    u0 = dut_under_cnt;
    for (int j = 0; j < 3; j++) begin
      wait_strobe(ok);
      checks++;
      if (underrun !== (j != 0)) begin errors++; $display("FAIL starve_underrun[%0d]: got %b required %b", j, underrun, j != 0); end
    end
    @(negedge clk50mhz);
    checks++;
    if (dut_under_cnt - u0 !== 2) begin errors++; $display("FAIL starve_pulses: got %0d required 2", dut_under_cnt - u0); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      pull_frame(f, ok); if (!ok) break;
      e = exp_q.pop_front();
      checks++;
      if (f !== e) begin errors++; $display("FAIL starve_frame[%0d]: got %h required %h", i, f, e); end
      if (i >= n - 3) begin
        checks++;
        if (f !== 32'h80007FFF) begin errors++; $display("FAIL starve_value[%0d]: got %h required 80007fff", i, f); end
      end
    end
  endtask

  task automatic test_valid_hold();
    bit ok; frame_t f, e; int n;
    wait_strobe(ok);
    checks++;
    if (sample_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_start: got %b required 1", sample_ready); end
    sample_l = 16'h1357; sample_r = 16'h2468; sample_valid = 1'b1;
    @(negedge clk50mhz);
    for (int j = 0; j < 20; j++) begin
      sample_l = sample_l + 16'd3; sample_r = sample_r ^ 16'hFFFF;
      @(negedge clk50mhz);
      checks++;
      if (sample_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_low[%0d]: got %b required 0", j, sample_ready); end
    end
    wait_strobe(ok);
    checks++;
    if (sample_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_reopen: got %b required 1", sample_ready); end
    sample_valid = 1'b0;
    wait_strobe(ok);
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL hold_underrun: got %b required 1", underrun); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      pull_frame(f, ok); if (!ok) break;
      e = exp_q.pop_front();
      checks++;
      if (f !== e) begin errors++; $display("FAIL hold_frame[%0d]: got %h required %h", i, f, e); end
      if (i >= n - 2) begin
        checks++;
        if (f !== 32'h13572468) begin errors++; $display("FAIL hold_value[%0d]: got %h required 13572468", i, f); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; frame_t f, e; int n;
    wait_strobe(ok);
    repeat (20 * BCLK_DIV + 10) @(negedge clk50mhz);
    checks++;
    if (AUD_BCLK !== 1'b1) begin errors++; $display("FAIL pre_reset_bclk: got %b required 1", AUD_BCLK); end
    reset = 1'b1;
    @(negedge clk50mhz);
    checks++;
    if ({AUD_DACDAT, AUD_DACLRCK, AUD_BCLK, sample_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b required 0001", {AUD_DACDAT, AUD_DACLRCK, AUD_BCLK, sample_ready});
    end
    reset = 1'b0;
    send_sample(16'h1234, 16'h5678);
    wait_strobe(ok);
    checks++;
    if (k !== FRAME_CYC) begin errors++; $display("FAIL restart_time: got cycle %0d required %0d", k, FRAME_CYC); end
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL restart_underrun: got %b required 0", underrun); end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      pull_frame(f, ok); if (!ok) break;
      e = exp_q.pop_front();
      checks++;
      if (f !== e) begin errors++; $display("FAIL restart_frame[%0d]: got %h required %h", i, f, e); end
      if (i == n - 1) begin
        checks++;
        if (f !== 32'h12345678) begin errors++; $display("FAIL restart_value: got %h required 12345678", f); end
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; sample_valid = 1'b0; sample_l = '0; sample_r = '0;
    test_reset();
    test_single();
    test_stream();
    test_clocks();
    test_starve();
    test_valid_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
